// File: rtl/regfile_arbiter_if.sv
// regfile_arbiter_if: requester ports A/B and register-file side signals of the arbiter
interface regfile_arbiter_if #(
  parameter int WIDTH = 16,
  parameter int AW = 3
);
  logic a_req, a_we, a_ack;
  logic [AW-1:0] a_addr;
  logic [WIDTH-1:0] a_wdata, a_rdata;
  logic b_req, b_we, b_ack;
  logic [AW-1:0] b_addr;
  logic [WIDTH-1:0] b_wdata, b_rdata;
  logic [AW-1:0] rf_rr1, rf_wr;
  logic rf_regW;
  logic [WIDTH-1:0] rf_dataW, rf_read1;
  logic busy;
  modport slave (
    input a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, rf_read1,
    output a_ack, a_rdata, b_ack, b_rdata, rf_rr1, rf_wr, rf_regW, rf_dataW, busy
  );
  modport master (
    output a_req, a_we, a_addr, a_wdata, b_req, b_we, b_addr, b_wdata, rf_read1,
    input a_ack, a_rdata, b_ack, b_rdata, rf_rr1, rf_wr, rf_regW, rf_dataW, busy
  );
endinterface

// File: rtl/regfile_arbiter.sv
// regfile_arbiter: round-robin two-port register-file arbiter with post-reset clear walk
module regfile_arbiter #(
  parameter int WIDTH = 16,
  parameter int AW = 3,
  parameter bit INIT_CLEAR = 1'b1,
  parameter logic [WIDTH-1:0] INIT_VALUE = '0
) (
  input logic clock,
  input logic reset,
  regfile_arbiter_if.slave bus
);
  typedef enum logic {INIT, IDLE} state_t;
  state_t state, state_nxt;
  logic [AW:0] cnt, cnt_nxt;
  logic ptr, a_el, b_el, ga, gb;
  logic [AW-1:0] rr1_q, wr_q;
  logic [WIDTH-1:0] dataw_q;
  always_ff @(posedge clock)
    if (reset) state <= INIT_CLEAR ? INIT : IDLE;
    else state <= state_nxt;
  // counter MSB rising marks the write of the last address
  always_comb begin
    cnt_nxt = cnt + (AW+1)'(1);
    state_nxt = (state == INIT && cnt_nxt[AW]) ? IDLE : state;
  end
  always_comb begin
    a_el = bus.a_req & ~bus.a_ack;
    b_el = bus.b_req & ~bus.b_ack;
    ga = ~reset & (state == IDLE) & a_el & (~b_el | ~ptr);
    gb = ~reset & (state == IDLE) & b_el & (~a_el | ptr);
    bus.busy = state == INIT;
    bus.rf_regW = ~reset & ((state == INIT) | (ga & bus.a_we) | (gb & bus.b_we));
    bus.rf_wr = (state == INIT) ? cnt[AW-1:0] : ga ? bus.a_addr : gb ? bus.b_addr : wr_q;
    bus.rf_dataW = (state == INIT) ? INIT_VALUE : ga ? bus.a_wdata : gb ? bus.b_wdata : dataw_q;
    bus.rf_rr1 = ga ? bus.a_addr : gb ? bus.b_addr : rr1_q;
  end
  always_ff @(posedge clock) begin
    rr1_q <= bus.rf_rr1;
    wr_q <= bus.rf_wr;
    dataw_q <= bus.rf_dataW;
    if (reset) begin
      cnt <= '0;
      ptr <= 1'b0;
      bus.a_ack <= 1'b0;
      bus.b_ack <= 1'b0;
      bus.a_rdata <= '0;
      bus.b_rdata <= '0;
    end else begin
      if (state == INIT) cnt <= cnt_nxt;
      if (state == IDLE && a_el && b_el) ptr <= ~ptr;
      bus.a_ack <= ga;
      bus.b_ack <= gb;
      if (ga && !bus.a_we) bus.a_rdata <= bus.rf_read1;
      if (gb && !bus.b_we) bus.b_rdata <= bus.rf_read1;
    end
  end
endmodule

// File: tb/tb_regfile_arbiter.sv
// tb_regfile_arbiter: table-driven and scoreboard checks of regfile_arbiter against a register-file model
module tb_regfile_arbiter;
  logic clock = 1'b0, reset = 1'b1;
  int tests = 0, fails = 0;
  regfile_arbiter_if #(.WIDTH(16), .AW(3)) bus();
  regfile_arbiter #(.WIDTH(16), .AW(3), .INIT_CLEAR(1'b1), .INIT_VALUE(16'h0000)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave)
  );
  logic [15:0] mem [8] = '{default: 16'hDEAD};
  always #5 clock = ~clock;
  always @(posedge clock) if (bus.rf_regW) mem[bus.rf_wr] <= bus.rf_dataW;
  assign bus.rf_read1 = mem[bus.rf_rr1];

  typedef struct {logic we; logic [15:0] rdata;} exp_t;
  typedef struct {bit pb; logic we; logic [2:0] addr; logic [15:0] wd; logic [15:0] er;} vec_t;
  exp_t qa[$], qb[$];
  exp_t ea, eb;
  logic pa = 1'b0, pbk = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  // scoreboard: every ack pops one expectation; acks must be single-cycle
  always @(negedge clock) begin
    if (bus.a_ack === 1'b1) begin
      chk("a_ack_pulse", pa, 1'b0);
      if (qa.size() == 0) begin
        tests++; fails++;
        $display("FAIL a_ack_unexpected: got ack with empty queue");
      end else begin
        ea = qa.pop_front();
        if (!ea.we) chk("a_rdata", bus.a_rdata, ea.rdata);
      end
    end
    if (bus.b_ack === 1'b1) begin
      chk("b_ack_pulse", pbk, 1'b0);
      if (qb.size() == 0) begin
        tests++; fails++;
        $display("FAIL b_ack_unexpected: got ack with empty queue");
      end else begin
        eb = qb.pop_front();
        if (!eb.we) chk("b_rdata", bus.b_rdata, eb.rdata);
      end
    end
    pa = bus.a_ack === 1'b1;
    pbk = bus.b_ack === 1'b1;
  end

  task automatic do_req(input bit pb, input logic we, input logic [2:0] addr,
                        input logic [15:0] wd, input logic [15:0] er);
    int n = 0;
    logic ack;
    if (pb) begin
      qb.push_back('{we, er});
      bus.b_req = 1'b1; bus.b_we = we; bus.b_addr = addr; bus.b_wdata = wd;
    end else begin
      qa.push_back('{we, er});
      bus.a_req = 1'b1; bus.a_we = we; bus.a_addr = addr; bus.a_wdata = wd;
    end
    #1;
    chk("rf_regW_grant", bus.rf_regW, we);
    chk("rf_addr_grant", we ? bus.rf_wr : bus.rf_rr1, addr);
    do begin
      tick;
      n++;
      ack = pb ? bus.b_ack : bus.a_ack;
    end while (ack !== 1'b1 && n < 20);
    chk("ack_seen", ack, 1'b1);
    chk("ack_latency", n, 1);
    if (pb) bus.b_req = 1'b0; else bus.a_req = 1'b0;
  endtask

  task automatic walk_check;
    for (int i = 0; i < 8; i++) begin
      chk("walk_busy", bus.busy, 1'b1);
      chk("walk_regW", bus.rf_regW, 1'b1);
      chk("walk_addr", bus.rf_wr, i);
      chk("walk_data", bus.rf_dataW, 16'h0000);
      tick;
    end
    chk("walk_done_busy", bus.busy, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vec_t tbl[10];
    tbl[0] = '{1'b0, 1'b0, 3'd5, 16'h0000, 16'h0000};
    tbl[1] = '{1'b0, 1'b1, 3'd3, 16'hBEEF, 16'h0000};
    tbl[2] = '{1'b0, 1'b0, 3'd3, 16'h0000, 16'hBEEF};
    tbl[3] = '{1'b1, 1'b1, 3'd1, 16'h0A0A, 16'h0000};
    tbl[4] = '{1'b0, 1'b0, 3'd1, 16'h0000, 16'h0A0A};
    tbl[5] = '{1'b1, 1'b0, 3'd3, 16'h0000, 16'hBEEF};
    tbl[6] = '{1'b0, 1'b1, 3'd7, 16'h7777, 16'h0000};
    tbl[7] = '{1'b1, 1'b0, 3'd7, 16'h0000, 16'h7777};
    tbl[8] = '{1'b1, 1'b0, 3'd0, 16'h0000, 16'h0000};
    tbl[9] = '{1'b0, 1'b1, 3'd5, 16'h5555, 16'h0000};
    {bus.a_req, bus.a_we, bus.a_addr, bus.a_wdata} = '0;
    {bus.b_req, bus.b_we, bus.b_addr, bus.b_wdata} = '0;
    // reset state and clear walk
    tick;
    chk("rst_a_ack", bus.a_ack, 1'b0);
    chk("rst_b_ack", bus.b_ack, 1'b0);
    chk("rst_a_rdata", bus.a_rdata, 16'h0);
    chk("rst_b_rdata", bus.b_rdata, 16'h0);
    chk("rst_busy", bus.busy, 1'b1);
    chk("rst_regW", bus.rf_regW, 1'b0);
    reset = 1'b0;
    #1;
    walk_check;
    for (int i = 0; i < 10; i++) begin
      do_req(tbl[i].pb, tbl[i].we, tbl[i].addr, tbl[i].wd, tbl[i].er);
      tick;
    end
    // contention: both held, expect A,B,A,B
    qa.push_back('{1'b0, 16'hBEEF}); qa.push_back('{1'b0, 16'hBEEF});
    qb.push_back('{1'b0, 16'h0A0A}); qb.push_back('{1'b0, 16'h0A0A});
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 3'd3;
    bus.b_req = 1'b1; bus.b_we = 1'b0; bus.b_addr = 3'd1;
    for (int c = 1; c <= 4; c++) begin
      tick;
      chk("rr_a_ack", bus.a_ack, c % 2 == 1);
      chk("rr_b_ack", bus.b_ack, c % 2 == 0);
    end
    bus.a_req = 1'b0; bus.b_req = 1'b0;
    tick;
    // read after write across ports in back-to-back cycles
    fork
      do_req(1'b1, 1'b1, 3'd2, 16'h1234, 16'h0000);
      begin
        tick;
        do_req(1'b0, 1'b0, 3'd2, 16'h0000, 16'h1234);
      end
    join
    tick;
    // request raised in walk cycle 3 waits for IDLE
    reset = 1'b1;
    tick;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) tick;
    qa.push_back('{1'b0, 16'h0000});
    bus.a_req = 1'b1; bus.a_we = 1'b0; bus.a_addr = 3'd5;
    for (int i = 3; i < 8; i++) begin
      #1;
      chk("init_no_ack", bus.a_ack, 1'b0);
      chk("init_busy", bus.busy, 1'b1);
      tick;
    end
    chk("idle_first_busy", bus.busy, 1'b0);
    chk("idle_first_ack", bus.a_ack, 1'b0);
    tick;
    chk("idle_grant_ack", bus.a_ack, 1'b1);
    bus.a_req = 1'b0;
    tick;
    // reset on a granted write suppresses it; reset mid-walk restarts at 0
    bus.a_req = 1'b1; bus.a_we = 1'b1; bus.a_addr = 3'd6; bus.a_wdata = 16'hFFFF;
    reset = 1'b1;
    #1;
    chk("rst_grant_regW", bus.rf_regW, 1'b0);
    tick;
    chk("rst_grant_ack", bus.a_ack, 1'b0);
    chk("rst_grant_busy", bus.busy, 1'b1);
    reset = 1'b0;
    bus.a_req = 1'b0;
    for (int i = 0; i < 3; i++) tick;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    #1;
    walk_check;
    do_req(1'b0, 1'b0, 3'd6, 16'h0000, 16'h0000);
    tick;
    tick;
    chk("qa_drained", qa.size(), 0);
    chk("qb_drained", qb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
